evt_stream_merge_arbiter: RTL and testbench

EVT_STREAM_MERGE_ARBITER -- requirements
Module: evt_stream_merge_arbiter

---
 rtl/sne_evt_stream_pkg.sv | 22 ++
 rtl/sne_event_stream_if.sv | 12 +
 rtl/evt_rr_arbiter.sv | 45 ++++
 rtl/evt_stream_merge_arbiter.sv | 120 ++++++++++++
 tb/tb_evt_stream_merge_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/sne_evt_stream_pkg.sv
// rtl/sne_evt_stream_pkg.sv - event stream types shared by the SNE stream blocks
package sne_evt_stream_pkg;

  localparam int OP_WIDTH   = 2;
  localparam int TS_WIDTH   = 8;
  localparam int ADDR_WIDTH = 12;

  typedef logic [TS_WIDTH-1:0] timestamp_t;

  typedef enum logic [OP_WIDTH-1:0] {
    EVT_SPIKE  = 2'd0,
    EVT_UPDATE = 2'd1,
    EVT_TIME   = 2'd2
  } evt_op_e;

  typedef struct packed {
    evt_op_e                op;
    timestamp_t             ts;
    logic [ADDR_WIDTH-1:0]  addr;
  } sne_evt_t;

endpackage

// File: rtl/sne_event_stream_if.sv
// rtl/sne_event_stream_if.sv - valid/ready event stream with producer and consumer views
interface SNE_EVENT_STREAM;
  import sne_evt_stream_pkg::*;

  sne_evt_t evt;
  logic     valid;
  logic     ready;

  modport src (output evt, output valid, input ready);
  modport dst (input evt, input valid, output ready);

endinterface

// File: rtl/evt_rr_arbiter.sv
// rtl/evt_rr_arbiter.sv - round-robin one-hot grant; pointer moves past the winner on advance
module evt_rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             advance_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [IDX_W-1:0] ptr_q;
  logic             found;
  int               j;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    j         = 0;
    // Scan starting at the pointer, wrapping once around the request vector.
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!found && req_i[j[IDX_W-1:0]]) begin
        found     = 1'b1;
        gnt_idx_o = j[IDX_W-1:0];
      end
    end
    gnt_valid_o = found & advance_i;
    if (gnt_valid_o) gnt_o[gnt_idx_o] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (gnt_valid_o) begin
      ptr_q <= (int'(gnt_idx_o) == N-1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/evt_stream_merge_arbiter.sv
// rtl/evt_stream_merge_arbiter.sv - merges filtered event streams; spikes round-robin, time events aligned
module evt_stream_merge_arbiter
  import sne_evt_stream_pkg::*;
#(
  parameter int N_INPUTS  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_INPUTS-1:0]  enable_mask_i,
  SNE_EVENT_STREAM.dst         evt_stream_dst [N_INPUTS],
  SNE_EVENT_STREAM.src         evt_stream_src,
  output logic                 barrier_o,
  output logic                 ts_mismatch_o,
  output logic [CNT_WIDTH-1:0] time_cnt_o
);

  localparam int IDX_W = $clog2(N_INPUTS);

  typedef enum logic [1:0] {ST_ARB, ST_PARTIAL, ST_ALIGN} state_e;

  state_e              state_q, state_d;
  sne_evt_t            in_evt [N_INPUTS];
  logic [N_INPUTS-1:0] in_valid, in_ready, parked, spike_req, rr_gnt;
  logic [IDX_W-1:0]    rr_idx, low_idx;
  logic                rr_valid, rr_en, slot_free, any_parked, all_parked, align_fire, ts_diff;
  sne_evt_t            out_evt_q;
  logic                out_valid_q;

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_in
    assign in_valid[g]              = evt_stream_dst[g].valid;
    assign in_evt[g]                = evt_stream_dst[g].evt;
    assign evt_stream_dst[g].ready  = in_ready[g];
    assign parked[g]    = enable_mask_i[g] & in_valid[g] & (in_evt[g].op == EVT_TIME);
    assign spike_req[g] = enable_mask_i[g] & in_valid[g] &
                          ((in_evt[g].op == EVT_SPIKE) | (in_evt[g].op == EVT_UPDATE));
  end

  assign slot_free  = ~out_valid_q | evt_stream_src.ready;
  assign any_parked = |parked;
  assign all_parked = (|enable_mask_i) & (parked == enable_mask_i);
  assign align_fire = ~rst_i & slot_free & all_parked;
  assign rr_en      = ~rst_i & slot_free & ~align_fire;

  always_comb begin
    low_idx = '0;
    for (int i = N_INPUTS-1; i >= 0; i--) begin
      if (enable_mask_i[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    ts_diff = 1'b0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (enable_mask_i[i] && (in_evt[i].ts != in_evt[low_idx].ts)) ts_diff = 1'b1;
    end
  end

  evt_rr_arbiter #(.N(N_INPUTS)) u_rr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (spike_req),
    .advance_i   (rr_en),
    .gnt_o       (rr_gnt),
    .gnt_idx_o   (rr_idx),
    .gnt_valid_o (rr_valid)
  );

  // An aligned time event retires the head of every enabled input at once.
  assign in_ready = align_fire ? enable_mask_i : rr_gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q   <= 1'b0;
      out_evt_q     <= '0;
      time_cnt_o    <= '0;
      ts_mismatch_o <= 1'b0;
    end else begin
      if (slot_free) begin
        out_valid_q <= align_fire | rr_valid;
        if (align_fire)    out_evt_q <= in_evt[low_idx];
        else if (rr_valid) out_evt_q <= in_evt[rr_idx];
      end
      if (align_fire) begin
        time_cnt_o <= time_cnt_o + CNT_WIDTH'(1);
        if (ts_diff) ts_mismatch_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_ARB;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB: begin
        if (!align_fire) begin
          if (all_parked)      state_d = ST_ALIGN;
          else if (any_parked) state_d = ST_PARTIAL;
        end
      end
      ST_PARTIAL: begin
        if (align_fire || !any_parked) state_d = ST_ARB;
        else if (all_parked)           state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (align_fire || !any_parked) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  assign barrier_o            = (state_q != ST_ARB);
  assign evt_stream_src.valid = out_valid_q;
  assign evt_stream_src.evt   = out_evt_q;

endmodule

// File: tb/tb_evt_stream_merge_arbiter.sv
// tb/tb_evt_stream_merge_arbiter.sv - scoreboard bench for the event stream merge arbiter
module tb_evt_stream_merge_arbiter;
  import sne_evt_stream_pkg::*;

  localparam int N  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  mask;
  logic          out_ready;
  logic          barrier, ts_mm;
  logic [CW-1:0] time_cnt;
  logic          drv_valid [N];
  sne_evt_t      drv_evt [N];
  logic [N-1:0]  in_rdy;
  logic [N-1:0]  took;
  sne_evt_t      src_q [N][$];
  sne_evt_t      exp_q [$];
  int n_checks = 0, n_errors = 0, cyc = 0;
  int first_take = -1, first_out = -1, last_out = 0, n_out = 0;

  always #5 clk = ~clk;

  SNE_EVENT_STREAM in_if [N] ();
  SNE_EVENT_STREAM out_if ();

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign in_if[g].valid = drv_valid[g];
    assign in_if[g].evt   = drv_evt[g];
    assign in_rdy[g]      = in_if[g].ready;
  end
  assign out_if.ready = out_ready;

  evt_stream_merge_arbiter #(.N_INPUTS(N), .CNT_WIDTH(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_mask_i  (mask),
    .evt_stream_dst (in_if),
    .evt_stream_src (out_if),
    .barrier_o      (barrier),
    .ts_mismatch_o  (ts_mm),
    .time_cnt_o     (time_cnt)
  );

  function automatic sne_evt_t mk(evt_op_e op, int ts, int addr);
    sne_evt_t e;
    e.op   = op;
    e.ts   = timestamp_t'(ts);
    e.addr = ADDR_WIDTH'(addr);
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      drv_valid[i] = (src_q[i].size() > 0);
      drv_evt[i]   = '0;
      if (src_q[i].size() > 0) drv_evt[i] = src_q[i][0];
    end
  endtask

  // Observe handshakes before the edge, then retire consumed heads just after it.
  task automatic tick();
    sne_evt_t e;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) took[i] = drv_valid[i] & in_rdy[i];
    if (|took && first_take < 0) first_take = cyc;
    if (out_if.valid && out_ready) begin
      n_out++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(out_if.valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("out_evt", 32'(out_if.evt), 32'(e));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (took[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    refresh();
  endtask

  task automatic drain(string tag, int max);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < max) begin
      tick();
      t++;
    end
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sne_evt_t e, a, b;
    rst = 1'b1; mask = '0; out_ready = 1'b1;
    refresh();
    repeat (2) tick();
    check("rst_valid",    32'(out_if.valid), 32'(0));
    check("rst_time_cnt", 32'(time_cnt),     32'(0));
    check("rst_ts_mm",    32'(ts_mm),        32'(0));
    check("rst_barrier",  32'(barrier),      32'(0));
    rst = 1'b0;

    // Four busy inputs, three spikes each: strict rotation at full rate.
    mask = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        e = mk(EVT_SPIKE, 0, i*16 + k);
        src_q[i].push_back(e);
        exp_q.push_back(e);
      end
    end
    refresh();
    first_take = -1; first_out = -1; n_out = 0;
    drain("rr_drain", 40);
    check("rr_first_latency", 32'(first_out - first_take), 32'(1));
    check("rr_out_count",     32'(n_out),                  32'(12));
    check("rr_throughput",    32'(last_out - first_out),   32'(11));

    // Inputs 0-2 parked on ts=5 while input 3 still has spikes to send.
    for (int i = 0; i < 3; i++) src_q[i].push_back(mk(EVT_TIME, 5, i));
    for (int k = 0; k < 3; k++) begin
      e = mk(EVT_SPIKE, 1, 48 + k);
      src_q[3].push_back(e);
      exp_q.push_back(e);
    end
    src_q[3].push_back(mk(EVT_TIME, 5, 3));
    exp_q.push_back(mk(EVT_TIME, 5, 0));
    refresh();
    tick(); tick();
    check("s2_barrier", 32'(barrier), 32'(1));
    drain("s2_drain", 20);
    tick(); tick();
    check("s2_time_cnt", 32'(time_cnt), 32'(1));
    check("s2_barrier_clear", 32'(barrier), 32'(0));
    check("s2_inputs_consumed",
          32'(src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()), 32'(0));

    // Aligned time events with one odd timestamp.
    src_q[0].push_back(mk(EVT_TIME, 5, 0));
    src_q[1].push_back(mk(EVT_TIME, 5, 1));
    src_q[2].push_back(mk(EVT_TIME, 6, 2));
    src_q[3].push_back(mk(EVT_TIME, 5, 3));
    exp_q.push_back(mk(EVT_TIME, 5, 0));
    refresh();
    drain("s3_drain", 10);
    tick();
    check("s3_ts_mm",    32'(ts_mm),    32'(1));
    check("s3_time_cnt", 32'(time_cnt), 32'(2));

    // Input 3 idle keeps the barrier up until its mask bit is cleared.
    for (int i = 0; i < 3; i++) src_q[i].push_back(mk(EVT_TIME, 7, i));
    refresh();
    repeat (3) tick();
    check("s4_barrier_held", 32'(barrier),      32'(1));
    check("s4_no_out",       32'(out_if.valid), 32'(0));
    check("s4_parked_ready", 32'(in_rdy),       32'(0));
    mask = 4'b0111;
    exp_q.push_back(mk(EVT_TIME, 7, 0));
    tick();
    check("s4_release_ready", 32'(took), 32'(4'b0111));
    drain("s4_drain", 5);
    tick();
    check("s4_barrier_rel",  32'(barrier),  32'(0));
    check("s4_time_cnt",     32'(time_cnt), 32'(3));
    check("s4_ts_mm_sticky", 32'(ts_mm),    32'(1));

    // Single enabled input: time events pass immediately; counter wraps at 16.
    mask = 4'b0001;
    for (int k = 0; k < 13; k++) begin
      e = mk(EVT_TIME, k, 100 + k);
      src_q[0].push_back(e);
      exp_q.push_back(e);
    end
    refresh();
    first_take = -1; first_out = -1; n_out = 0;
    tick();
    check("s5_first_time_ready", 32'(took[0]), 32'(1));
    drain("s5_drain", 30);
    check("s5_throughput", 32'(last_out - first_out), 32'(12));
    tick();
    check("s5_time_cnt_wrap", 32'(time_cnt), 32'(0));

    // Empty mask grants nothing; then a stalled output holds; then reset discards it.
    mask = '0;
    a = mk(EVT_SPIKE, 2, 200);
    b = mk(EVT_SPIKE, 2, 201);
    src_q[1].push_back(a);
    src_q[1].push_back(b);
    refresh();
    repeat (3) tick();
    check("s6_mask0_no_grant", 32'(took),         32'(0));
    check("s6_mask0_no_out",   32'(out_if.valid), 32'(0));
    mask = 4'b1111;
    out_ready = 1'b0;
    tick();
    check("s6_grant", 32'(took), 32'(4'b0010));
    for (int k = 0; k < 5; k++) begin
      tick();
      check("s6_hold_valid",    32'(out_if.valid), 32'(1));
      check("s6_hold_evt",      32'(out_if.evt),   32'(a));
      check("s6_hold_no_ready", 32'(took),         32'(0));
    end
    rst = 1'b1;
    tick();
    check("s6_rst_no_ready", 32'(took),         32'(0));
    check("s6_rst_valid",    32'(out_if.valid), 32'(0));
    check("s6_rst_time_cnt", 32'(time_cnt),     32'(0));
    check("s6_rst_ts_mm",    32'(ts_mm),        32'(0));
    rst = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back(b);
    drain("s6_drain", 10);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
